seg7_scan: RTL and testbench

Four-digit multiplexed seven-segment driver for the digital clock. It sits directly downstream of the minute/hour counter and consumes its four BCD digits (minutes units, minutes tens, hours units, hours tens). It drives a common-anode, active-low display, time-multiplexing one digit at a time. It includes anti-ghosting blanking, leading-zero suppression on the hours-tens digit, and frame-coherent digit sampling.

---
 rtl/seg7_scan.sv | 150 +++++++++++++++
 tb/tb_seg7_scan.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed seven-segment driver, active-low, with blanking and frame-coherent shadows
// Optional colon blink on dp guarded by COLON_BLINK_EN.
module seg7_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] min,
  input  logic [3:0] min2,
  input  logic [3:0] hr1,
  input  logic [3:0] hr2,
  input  logic       sec_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic          primed;
  logic [3:0]    sh_min;
  logic [3:0]    sh_min2;
  logic [3:0]    sh_hr1;
  logic [3:0]    sh_hr2;
  logic [3:0]    digit;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;
  logic          last;
  logic          capture;

  assign last    = (cnt == CW'(SCAN_DIV - 1));
  // Shadows reload on the first edge out of reset and at every frame boundary.
  assign capture = !primed || (last && (slot == 2'd3));

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    case (slot)
      2'd0:    digit = sh_min;
      2'd1:    digit = sh_min2;
      2'd2:    digit = sh_hr1;
      default: digit = sh_hr2;
    endcase
  end

`ifdef COLON_BLINK_EN
  logic blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink <= 1'b0;
    end else if (sec_tick) begin
      blink <= ~blink;
    end
  end
`else
  logic unused_sec_tick;
  assign unused_sec_tick = sec_tick;
`endif

  always_comb begin
    state_next = state;
    an_d       = 4'b1111;
    seg_d      = 7'h7F;
    dp_d       = 1'b1;
    case (state)
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (last) begin
          state_next = BLANK;
        end
        // A zero hours-tens digit stays dark for the whole slot.
        if (!((slot == 2'd3) && (sh_hr2 == 4'd0))) begin
          an_d  = ~(4'b0001 << slot);
          seg_d = decode(digit);
        end
`ifdef COLON_BLINK_EN
        if ((slot == 2'd2) && blink) begin
          dp_d = 1'b0;
        end
`endif
      end
      default: state_next = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      cnt     <= '0;
      slot    <= 2'd0;
      primed  <= 1'b0;
      sh_min  <= 4'd0;
      sh_min2 <= 4'd0;
      sh_hr1  <= 4'd0;
      sh_hr2  <= 4'd0;
      an      <= 4'b1111;
      seg     <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      state  <= state_next;
      cnt    <= last ? '0 : cnt + 1'b1;
      primed <= 1'b1;
      if (last) begin
        slot <= slot + 2'd1;
      end
      if (capture) begin
        sh_min  <= min;
        sh_min2 <= min2;
        sh_hr1  <= hr1;
        sh_hr2  <= hr2;
      end
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan with SCAN_DIV=8, BLANK_CYCLES=2
module tb_seg7_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] min = 4'd4;
  logic [3:0] min2 = 4'd3;
  logic [3:0] hr1 = 4'd2;
  logic [3:0] hr2 = 4'd1;
  logic       sec_tick = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int passed = 0;
  int total = 0;
  bit done = 1'b0;
  int ed = 0;

  seg7_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .min(min), .min2(min2), .hr1(hr1), .hr2(hr2),
    .sec_tick(sec_tick), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Model: time index t since reset release gives slot and in-slot position arithmetically.
  initial begin
    int e;
    int t;
    int sl;
    int c;
    logic [3:0] sh [4];
    logic bl;
    logic [3:0] ea;
    logic [6:0] es;
    logic edp;
    e = 0;
    bl = 1'b0;
    foreach (sh[i]) sh[i] = 4'd0;
    forever begin
      @(posedge clk);
      ea = 4'hF;
      es = 7'h7F;
      edp = 1'b1;
      if (!rst_n) begin
        e = 0;
        bl = 1'b0;
        foreach (sh[i]) sh[i] = 4'd0;
      end else begin
        t = e;
        e++;
        sl = (t / SD) % 4;
        c = t % SD;
        if (c >= BC) begin
          if (!(sl == 3 && sh[3] == 4'd0)) begin
            ea = 4'hF ^ (4'h1 << sl);
            es = glyph(sh[sl]);
          end
`ifdef COLON_BLINK_EN
          if (sl == 2 && bl) edp = 1'b0;
`endif
        end
        if (t == 0 || (t % FR) == FR - 1) begin
          sh[0] = min; sh[1] = min2; sh[2] = hr1; sh[3] = hr2;
        end
        if (sec_tick) bl = ~bl;
      end
      #2;
      if (!done) check("cycle", {20'd0, an, seg, dp}, {20'd0, ea, es, edp});
    end
  end

  task automatic at_edge(input int k);
    while (ed < k) begin
      @(negedge clk);
      ed++;
    end
  endtask

  initial begin
    int lz;
    logic exp_dp_on;
`ifdef COLON_BLINK_EN
    exp_dp_on = 1'b0;
`else
    exp_dp_on = 1'b1;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_seg_dp", {24'd0, seg, dp}, {24'd0, 7'h7F, 1'b1});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ed = 0;

    at_edge(2);  check("blank_edge2", {28'd0, an}, 32'hF);
    at_edge(3);  check("slot0_an", {28'd0, an}, 32'hE);
                 check("slot0_seg", {25'd0, seg}, {25'd0, 7'b0011001});
    at_edge(9);  check("slot0_off", {28'd0, an}, 32'hF);
    at_edge(11); check("slot1", {21'd0, an, seg}, {21'd0, 4'b1101, 7'b0110000});
    at_edge(19); check("slot2", {21'd0, an, seg}, {21'd0, 4'b1011, 7'b0100100});
    at_edge(27); check("slot3", {21'd0, an, seg}, {21'd0, 4'b0111, 7'b1111001});
    at_edge(35); check("repeat", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b0011001});

    at_edge(40); min = 4'hC;
    at_edge(67); check("invalid_bcd", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b0111111});
    at_edge(70); min = 4'd5;
    at_edge(75); check("other_digit", {21'd0, an, seg}, {21'd0, 4'b1101, 7'b0110000});
    at_edge(99); check("min5", {25'd0, seg}, {25'd0, 7'b0010010});
    at_edge(113); min = 4'd6;
    at_edge(127); check("hr2_still", {21'd0, an, seg}, {21'd0, 4'b0111, 7'b1111001});
    at_edge(131); check("coherent_min6", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b0000010});

    at_edge(140); hr2 = 4'd0; hr1 = 4'd9;
    lz = 0;
    for (int k = 161; k <= 256; k++) begin
      at_edge(k);
      if (an[3] == 1'b0) lz++;
      if (k == 180) check("hr1_nine", {21'd0, an, seg}, {21'd0, 4'b1011, 7'b0010000});
    end
    check("lz_suppressed", lz, 0);

    at_edge(260); sec_tick = 1'b1;
    at_edge(261); sec_tick = 1'b0;
    at_edge(306); check("dp_blank", {31'd0, dp}, 32'd1);
    at_edge(308); check("dp_colon", {31'd0, dp}, {31'd0, exp_dp_on});
    at_edge(314); check("dp_slot3", {31'd0, dp}, 32'd1);
    at_edge(320); sec_tick = 1'b1;
    at_edge(321); sec_tick = 1'b0;
    at_edge(340); check("dp_off", {31'd0, dp}, 32'd1);

    at_edge(356); check("pre_reset", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b0000010});
    #2 rst_n = 1'b0;
    #1 check("async_reset", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ed = 0;
    at_edge(2); check("rerelease_blank", {28'd0, an}, 32'hF);
    at_edge(3); check("rerelease_an0", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b0000010});
    at_edge(40);

    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
